decode_issue_buffer: RTL and testbench
======================================

DECODE_ISSUE_BUFFER -- requirements
Module: decode_issue_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, >=2.
REQ-002 Parameter PC_W, default 32, width of the program-counter field stored with each entry.
REQ-003 Parameter NUM_REGS, default 32, number of architectural registers tracked; register id width RID_W = $clog2(NUM_REGS).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream offers an instruction.
REQ-007 in_ready  out  1  buffer can accept this cycle.
REQ-008 in_instruction  in  32  decompressed RV32 instruction (compressed expansion done upstream).
REQ-009 in_pc  in  PC_W  pc of in_instruction.
REQ-010 out_valid  out  1  head instruction issuable this cycle.
REQ-011 out_ready  in  1  decode accepts head.
REQ-012 out_instruction  out  32  head instruction.
REQ-013 out_pc  out  PC_W  head pc.
REQ-014 out_stall  out  1  head present but blocked by load-use hazard.
REQ-015 wb_en  in  1  register writeback this cycle.
REQ-016 wb_id  in  RID_W  writeback register id.
REQ-017 flush  in  1  synchronous discard of all queued entries.
REQ-018 occupancy  out  $clog2(DEPTH)+1  current entry count.

Function
REQ-019 Queue SHALL be FIFO, circular read/write pointers, wrap at DEPTH-1 -> 0.
REQ-020 Push SHALL occur on edge when in_valid && in_ready && !flush; in_ready = (occupancy < DEPTH); no same-cycle bypass through a full queue.
REQ-021 Pushed entry SHALL be visible at head no earlier than the cycle after push (1-cycle min latency).
REQ-022 Field decode from head: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
REQ-023 Source use: LUI 0110111, AUIPC 0010111, JAL 1101111 use none; OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011 use rs1 only; all other opcodes use rs1 and rs2.
REQ-024 Scoreboard: one busy bit per register; register 0 SHALL never read busy.
REQ-025 Hazard SHALL be true when a used source reg is busy and not cleared by same-cycle writeback (wb_en && wb_id == that source).
REQ-026 out_valid = (occupancy != 0) && !hazard && !flush; out_stall = (occupancy != 0) && hazard.
REQ-027 Pop (issue) SHALL occur on edge when out_valid && out_ready.
REQ-028 On issue of LOAD with rd != 0, busy[rd] SHALL set on that edge.
REQ-029 wb_en SHALL clear busy[wb_id] on the edge; if same-cycle issue sets same reg, set wins.
REQ-030 Simultaneous push and pop SHALL leave occupancy unchanged; both pointers advance.
REQ-031 flush SHALL zero occupancy and both pointers on the edge; concurrent push dropped, no pop; scoreboard retained (in-flight loads still write back).
REQ-032 out_instruction/out_pc SHALL be driven from head storage regardless of out_valid; contents undefined when empty.
REQ-033 occupancy SHALL never exceed DEPTH or underflow 0.

Reset
REQ-034 While reset_n low: occupancy 0, pointers 0, all busy bits 0, in_ready 1, out_valid 0, out_stall 0; asserted mid-operation, queued entries and busy bits discarded immediately.
REQ-035 First push permitted on first rising edge after reset_n deasserts.

Verification
REQ-036 Fill DEPTH=4 with out_ready=0 -> in_ready 0 after 4th push, occupancy 4; pop 4 -> instructions in push order, pointer wrap observed.
REQ-037 Issue LW x5 then ADD x6,x5,x1 -> ADD head gives out_stall 1, out_valid 0; wb_en=1 wb_id=5 -> ADD out_valid 1 same cycle.
REQ-038 LW x0 issued -> no busy set; following ADD x1,x0,x0 issues without stall.
REQ-039 Full queue, flush=1 with in_valid=1 -> next cycle occupancy 0, dropped input absent, busy bits preserved.
REQ-040 LUI x7 behind busy x5 with rs1/rs2 fields =5 -> no stall (sources unused).
REQ-041 reset_n low mid-stream with occupancy 3, busy[5]=1 -> occupancy 0, out_valid 0, busy cleared asynchronously.

Source files
------------

// File: rtl/decode_issue_buffer.sv
// Decode issue buffer: a small in-order instruction FIFO in front of decode.
// The head is held back while a source register waits on an outstanding load.
module decode_issue_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_W     = 32,
   parameter int unsigned NUM_REGS = 32,
   localparam int unsigned RID_W   = $clog2(NUM_REGS),
   localparam int unsigned PTR_W   = $clog2(DEPTH),
   localparam int unsigned CNT_W   = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instruction,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instruction,
   output logic [PC_W-1:0]  out_pc,
   output logic             out_stall,
   input  logic             wb_en,
   input  logic [RID_W-1:0] wb_id,
   input  logic             flush,
   output logic [CNT_W-1:0] occupancy
);

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_OPIMM  = 7'b0010011,
      OPC_LOAD   = 7'b0000011,
      OPC_JALR   = 7'b1100111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   logic [31:0]         instr_mem_q [DEPTH];
   logic [PC_W-1:0]     pc_mem_q    [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic       use_rs1, use_rs2;
   logic       rs1_busy, rs2_busy;
   logic       hazard, not_empty, push, pop, issue_load;

   assign out_instruction = instr_mem_q[rd_ptr_q];
   assign out_pc          = pc_mem_q[rd_ptr_q];
   assign occupancy       = cnt_q;

   assign opcode = out_instruction[6:0];
   assign rd     = out_instruction[11:7];
   assign rs1    = out_instruction[19:15];
   assign rs2    = out_instruction[24:20];

   always_comb begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
         end
         OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: use_rs2 = 1'b0;
         default: ;
      endcase
   end

   // A writeback landing this cycle already unblocks its register; x0 is never scanned.
   always_comb begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (busy_q[i] && !(wb_en && 32'(wb_id) == i)) begin
            if (32'(rs1) == i) rs1_busy = 1'b1;
            if (32'(rs2) == i) rs2_busy = 1'b1;
         end
      end
   end

   assign hazard     = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);
   assign not_empty  = (cnt_q != '0);
   assign in_ready   = (cnt_q < CNT_W'(DEPTH));
   assign out_valid  = not_empty && !hazard && !flush;
   assign out_stall  = not_empty && hazard;
   assign push       = in_valid && in_ready && !flush;
   assign pop        = out_valid && out_ready;
   assign issue_load = pop && (opcode == OPC_LOAD) && (rd != 5'd0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Clear first so a load issuing to the same register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (wb_en && 32'(wb_id) == i) busy_d[i] = 1'b0;
         if (issue_load && 32'(rd) == i) busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= in_instruction;
         pc_mem_q[wr_ptr_q]    <= in_pc;
      end
   end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Randomized plus directed bench for decode_issue_buffer, checked against a
// queue-and-busy-set reference model sampled on the falling clock edge.
module tb_decode_issue_buffer;
   localparam int unsigned DEPTH = 4;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid, in_ready, out_valid, out_ready, out_stall;
   logic [31:0] in_instruction, in_pc, out_instruction, out_pc;
   logic        wb_en, flush;
   logic [4:0]  wb_id;
   logic [2:0]  occupancy;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
   } ent_t;

   ent_t        sb_q[$];
   bit          busy_m[32];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] pc_n = 32'h1000;
   logic [6:0]  ops[10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_OPIMM, OP_LOAD,
                            OP_JALR, OP_SYSTEM, OP_OP, OP_STORE, OP_BRANCH};

   decode_issue_buffer #(.DEPTH(DEPTH), .PC_W(32), .NUM_REGS(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instruction(out_instruction), .out_pc(out_pc),
      .out_stall(out_stall), .wb_en(wb_en), .wb_id(wb_id),
      .flush(flush), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit src_blocked(input int r);
      return (r != 0) && busy_m[r] && !(wb_en && int'(wb_id) == r);
   endfunction

   function automatic bit model_hazard(input logic [31:0] ins);
      logic [6:0] op;
      bit u1, u2;
      op = ins[6:0];
      u1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
      u2 = u1 && !(op inside {OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM});
      return (u1 && src_blocked(int'(ins[19:15]))) || (u2 && src_blocked(int'(ins[24:20])));
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin : mon
      bit   hz, ev, do_pop, do_push;
      ent_t head;
      if (!reset_n) begin
         sb_q.delete();
         foreach (busy_m[i]) busy_m[i] = 1'b0;
      end
      hz = (sb_q.size() != 0) ? model_hazard(sb_q[0].ins) : 1'b0;
      ev = (sb_q.size() != 0) && !hz && !flush;
      chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
      chk("in_ready", 64'(in_ready), 64'(sb_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_stall", 64'(out_stall), 64'((sb_q.size() != 0) && hz));
      if (sb_q.size() != 0) begin
         chk("head_instr", 64'(out_instruction), 64'(sb_q[0].ins));
         chk("head_pc", 64'(out_pc), 64'(sb_q[0].pc));
      end
      if (reset_n) begin
         do_pop  = ev && out_ready;
         do_push = in_valid && (sb_q.size() < DEPTH) && !flush;
         if (wb_en) busy_m[wb_id] = 1'b0;
         if (do_pop) begin
            head = sb_q.pop_front();
            if (head.ins[6:0] == OP_LOAD && head.ins[11:7] != 5'd0)
               busy_m[head.ins[11:7]] = 1'b1;
         end
         if (flush) sb_q.delete();
         else if (do_push) sb_q.push_back('{ins: in_instruction, pc: in_pc});
      end
   end

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'(rd), op};
   endfunction

   task automatic drive(input bit iv, input logic [31:0] ins, input bit ordy,
                        input bit wbe, input logic [4:0] wid, input bit fl);
      in_valid = iv; in_instruction = ins; in_pc = pc_n;
      out_ready = ordy; wb_en = wbe; wb_id = wid; flush = fl;
      if (iv) pc_n = pc_n + 32'd4;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic push1(input logic [31:0] ins);
      drive(1'b1, ins, 1'b0, 1'b0, 5'd0, 1'b0); tick();
   endtask

   task automatic issue1();
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0); tick();
   endtask

   initial begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      #1 reset_n = 1'b0;
      repeat (3) tick();
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      reset_n = 1'b1;

      // fill, full, drain in order, then wrap with concurrent push/pop
      for (int i = 0; i < 4; i++) push1(mk(OP_OPIMM, i + 1, 0, 0));
      drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_occ", 64'(occupancy), 64'd4);
      tick();
      for (int i = 0; i < 4; i++) issue1();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, mk(OP_OP, i + 10, 0, 0), 1'b1, 1'b0, 5'd0, 1'b0); tick();
      end
      repeat (3) issue1();

      // load-use stall resolved by same-cycle writeback
      push1(mk(OP_LOAD, 5, 1, 0));
      issue1();
      push1(mk(OP_OP, 6, 5, 1));
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("lu_stall", 64'(out_stall), 64'd1);
      chk("lu_valid_blocked", 64'(out_valid), 64'd0);
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 1'b0);
      at_neg();
      chk("lu_wb_valid", 64'(out_valid), 64'd1);
      chk("lu_wb_stall", 64'(out_stall), 64'd0);
      tick();

      // load to x0 never marks busy
      push1(mk(OP_LOAD, 0, 0, 0));
      issue1();
      push1(mk(OP_OP, 1, 0, 0));
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("x0_valid", 64'(out_valid), 64'd1);
      tick();

      // LUI ignores its rs fields
      push1(mk(OP_LOAD, 5, 0, 0));
      issue1();
      push1(mk(OP_LUI, 7, 5, 5));
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("lui_valid", 64'(out_valid), 64'd1);
      chk("lui_stall", 64'(out_stall), 64'd0);
      tick();

      // flush a full queue with a concurrent push; x5 must stay busy
      for (int i = 0; i < 4; i++) push1(mk(OP_OPIMM, i + 8, 0, 0));
      drive(1'b1, mk(OP_OP, 3, 0, 0), 1'b1, 1'b0, 5'd0, 1'b1);
      at_neg();
      chk("flush_valid", 64'(out_valid), 64'd0);
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("flush_occ", 64'(occupancy), 64'd0);
      tick();
      push1(mk(OP_OP, 6, 5, 0));
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("flush_busy_kept", 64'(out_stall), 64'd1);
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 1'b0); tick();

      // asynchronous reset mid-stream
      push1(mk(OP_LOAD, 5, 0, 0));
      issue1();
      for (int i = 0; i < 3; i++) push1(mk(OP_OP, 6, 5, 1));
      drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("pre_rst_occ", 64'(occupancy), 64'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_occ", 64'(occupancy), 64'd0);
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_stall", 64'(out_stall), 64'd0);
      chk("async_rst_ready", 64'(in_ready), 64'd1);
      tick();
      tick();
      reset_n = 1'b1;
      push1(mk(OP_OP, 6, 5, 1));
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      at_neg();
      chk("rst_busy_cleared", 64'(out_valid), 64'd1);
      tick();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         logic [31:0] ins;
         ins = mk(ops[$urandom_range(0, 9)], int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         ins[31:25] = 7'($urandom);
         ins[14:12] = 3'($urandom);
         drive($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 3);
         tick();
      end

      // bounded drain
      for (int k = 0; k < 300 && occupancy != 3'd0; k++) begin
         drive(1'b0, 32'd0, 1'b1, 1'b1, 5'(k % 8), 1'b0);
         tick();
      end
      chk("drain_occ", 64'(occupancy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
